// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front-end: FSM states, key codes
// and one-hot decoding of the 11 key lines (digits 0-9 plus '#').
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int         NUM_KEYS  = 11;
    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [3:0] KEY_SHARP = 4'hA;

    // Bit index doubles as the key code, so '#' on bit 10 maps to 4'hA.
    function automatic logic [3:0] onehot_to_code(input logic [NUM_KEYS-1:0] vec);
        logic [3:0] code;
        code = KEY_NONE;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) code = 4'(i);
        end
        return code;
    endfunction

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] vec);
        return (vec != '0) && ((vec & (vec - NUM_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/key_sync2.sv
// N-bit two-flop synchroniser for asynchronous key lines, cleared by the
// active-low asynchronous reset.
module key_sync2 #(
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad conditioning: synchronises raw key lines, debounces press and release,
// rejects multi-key chords and drives registered level, strobe and code outputs.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 10000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CNT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] raw_key,
    output logic [9:0]          keypad,
    output logic                sharp,
    output logic                key_pulse,
    output logic [3:0]          key_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [NUM_KEYS-1:0] sync;
    key_state_e          state_q, state_d;
    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] out_q, out_d;
    logic [3:0]          code_q, code_d;
    logic                pulse_q, pulse_d;

    key_sync2 #(
        .WIDTH (NUM_KEYS)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .data_i (raw_key),
        .sync_o (sync)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            code_q  <= KEY_NONE;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs are registered on the qualifying edge so level, code and strobe move together.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        code_d  = code_q;
        pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                out_d  = '0;
                code_d = KEY_NONE;
                if (is_onehot(sync)) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (sync == cand_q) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = HELD;
                        out_d   = cand_q;
                        code_d  = onehot_to_code(cand_q);
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            HELD: begin
                if (sync != cand_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            // Any foreign key restarts the all-released count; the held key returning is a bounce.
            RELEASE_WAIT: begin
                if (sync == '0) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        out_d   = '0;
                        code_d  = KEY_NONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sync == cand_q) begin
                    state_d = HELD;
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign keypad    = out_q[9:0];
    assign sharp     = out_q[10];
    assign key_pulse = pulse_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed self-checking bench for keypad_debounce with DEBOUNCE_CNT=4,
// giving a press/release latency of 7 clock edges.
module tb_keypad_debounce;

    logic        clock;
    logic        reset;
    logic [10:0] raw_key;
    logic [9:0]  keypad;
    logic        sharp;
    logic        key_pulse;
    logic [3:0]  key_code;

    int errors = 0;
    int checks = 0;
    int pulseCount = 0;
    int doublePulse = 0;
    int sharpDrops = 0;
    int inconsistent = 0;
    bit trackSharp = 0;
    logic prevPulse = 1'b0;

    keypad_debounce #(
        .DEBOUNCE_CNT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_key   (raw_key),
        .keypad    (keypad),
        .sharp     (sharp),
        .key_pulse (key_pulse),
        .key_code  (key_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Mid-cycle observers for strobe count, back-to-back strobes, '#' drops and output consistency.
    always @(negedge clock) begin
        if (reset) begin
            if (key_pulse) pulseCount++;
            if (key_pulse && prevPulse) doublePulse++;
            if (trackSharp && !sharp) sharpDrops++;
            if ((key_code == 4'hF) != ((keypad == 10'h0) && !sharp)) inconsistent++;
            if ((keypad != 10'h0) && sharp) inconsistent++;
            prevPulse = key_pulse;
        end else begin
            prevPulse = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [10:0] v, input int n);
        raw_key = v;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int p0;
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL por_keypad: got %h expected %h", keypad, 10'h0); end
        checks++; if (sharp !== 1'b0) begin errors++; $display("[TB] FAIL por_sharp: got %b expected 0", sharp); end
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("[TB] FAIL por_pulse: got %b expected 0", key_pulse); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL por_code: got %h expected F", key_code); end
        tick();
        reset = 1'b1;
        applyStimulus(11'h004, 12);
        checks++; if (keypad !== 10'h004) begin errors++; $display("[TB] FAIL held_before_reset: got %h expected 004", keypad); end
        #3 reset = 1'b0;
        #1;
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL async_keypad: got %h expected 000", keypad); end
        checks++; if (sharp !== 1'b0) begin errors++; $display("[TB] FAIL async_sharp: got %b expected 0", sharp); end
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("[TB] FAIL async_pulse: got %b expected 0", key_pulse); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL async_code: got %h expected F", key_code); end
        repeat (2) tick();
        reset = 1'b1;
        p0 = pulseCount;
        repeat (6) tick();
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL requal_early: got %h expected 000", keypad); end
        tick();
        checks++; if (keypad !== 10'h004) begin errors++; $display("[TB] FAIL requal_keypad: got %h expected 004", keypad); end
        checks++; if (key_code !== 4'h2) begin errors++; $display("[TB] FAIL requal_code: got %h expected 2", key_code); end
        checks++; if (key_pulse !== 1'b1) begin errors++; $display("[TB] FAIL requal_pulse: got %b expected 1", key_pulse); end
        tick();
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("[TB] FAIL requal_pulse_end: got %b expected 0", key_pulse); end
        applyStimulus(11'h000, 10);
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL requal_release: got %h expected F", key_code); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL requal_pulse_count: got %0d expected 1", pulseCount - p0); end
    endtask

    task automatic test_clean_press();
        int p0;
        p0 = pulseCount;
        applyStimulus(11'h008, 6);
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL press_early: got %h expected 000", keypad); end
        tick();
        checks++; if (keypad !== 10'h008) begin errors++; $display("[TB] FAIL press_keypad: got %h expected 008", keypad); end
        checks++; if (key_code !== 4'h3) begin errors++; $display("[TB] FAIL press_code: got %h expected 3", key_code); end
        checks++; if (key_pulse !== 1'b1) begin errors++; $display("[TB] FAIL press_pulse: got %b expected 1", key_pulse); end
        tick();
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("[TB] FAIL press_pulse_end: got %b expected 0", key_pulse); end
        repeat (12) tick();
        applyStimulus(11'h000, 6);
        checks++; if (keypad !== 10'h008) begin errors++; $display("[TB] FAIL release_early: got %h expected 008", keypad); end
        tick();
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL release_keypad: got %h expected 000", keypad); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL release_code: got %h expected F", key_code); end
        repeat (4) tick();
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL press_pulse_count: got %0d expected 1", pulseCount - p0); end
    endtask

    task automatic test_press_bounce();
        int p0;
        p0 = pulseCount;
        for (int k = 0; k < 4; k++) applyStimulus((k % 2 == 0) ? 11'h001 : 11'h000, 2);
        applyStimulus(11'h001, 6);
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL bounce_early: got %h expected 000", keypad); end
        checks++; if (pulseCount - p0 !== 0) begin errors++; $display("[TB] FAIL bounce_premature_pulse: got %0d expected 0", pulseCount - p0); end
        tick();
        checks++; if (keypad !== 10'h001) begin errors++; $display("[TB] FAIL bounce_keypad: got %h expected 001", keypad); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL bounce_code: got %h expected 0", key_code); end
        checks++; if (key_pulse !== 1'b1) begin errors++; $display("[TB] FAIL bounce_pulse: got %b expected 1", key_pulse); end
        applyStimulus(11'h001, 5);
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", pulseCount - p0); end
        applyStimulus(11'h000, 10);
    endtask

    task automatic test_multi_key();
        int p0;
        p0 = pulseCount;
        applyStimulus(11'h003, 10);
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL multi_code: got %h expected F", key_code); end
        applyStimulus(11'h003, 10);
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL multi_keypad: got %h expected 000", keypad); end
        checks++; if (pulseCount - p0 !== 0) begin errors++; $display("[TB] FAIL multi_pulse_count: got %0d expected 0", pulseCount - p0); end
        applyStimulus(11'h000, 4);
    endtask

    task automatic test_sharp_with_key();
        int p0;
        int p1;
        p0 = pulseCount;
        applyStimulus(11'h400, 7);
        checks++; if (sharp !== 1'b1) begin errors++; $display("[TB] FAIL sharp_press: got %b expected 1", sharp); end
        checks++; if (key_code !== 4'hA) begin errors++; $display("[TB] FAIL sharp_code: got %h expected A", key_code); end
        sharpDrops = 0;
        trackSharp = 1'b1;
        applyStimulus(11'h420, 6);
        checks++; if (key_code !== 4'hA) begin errors++; $display("[TB] FAIL chord_code: got %h expected A", key_code); end
        applyStimulus(11'h020, 10);
        trackSharp = 1'b0;
        checks++; if (sharp !== 1'b1) begin errors++; $display("[TB] FAIL foreign_sharp: got %b expected 1", sharp); end
        checks++; if (key_code !== 4'hA) begin errors++; $display("[TB] FAIL foreign_code: got %h expected A", key_code); end
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL foreign_keypad: got %h expected 000", keypad); end
        checks++; if (sharpDrops !== 0) begin errors++; $display("[TB] FAIL foreign_sharp_drops: got %0d expected 0", sharpDrops); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL foreign_pulse_count: got %0d expected 1", pulseCount - p0); end
        applyStimulus(11'h000, 10);
        checks++; if (sharp !== 1'b0) begin errors++; $display("[TB] FAIL all_released_sharp: got %b expected 0", sharp); end
        p1 = pulseCount;
        applyStimulus(11'h020, 6);
        checks++; if (keypad !== 10'h0) begin errors++; $display("[TB] FAIL key5_early: got %h expected 000", keypad); end
        tick();
        checks++; if (keypad !== 10'h020) begin errors++; $display("[TB] FAIL key5_keypad: got %h expected 020", keypad); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("[TB] FAIL key5_code: got %h expected 5", key_code); end
        checks++; if (key_pulse !== 1'b1) begin errors++; $display("[TB] FAIL key5_pulse: got %b expected 1", key_pulse); end
        applyStimulus(11'h000, 10);
        checks++; if (pulseCount - p1 !== 1) begin errors++; $display("[TB] FAIL key5_pulse_count: got %0d expected 1", pulseCount - p1); end
    endtask

    task automatic test_release_bounce();
        int p0;
        p0 = pulseCount;
        applyStimulus(11'h400, 8);
        checks++; if (sharp !== 1'b1) begin errors++; $display("[TB] FAIL rb_press: got %b expected 1", sharp); end
        sharpDrops = 0;
        trackSharp = 1'b1;
        applyStimulus(11'h000, 2);
        applyStimulus(11'h400, 10);
        trackSharp = 1'b0;
        checks++; if (sharpDrops !== 0) begin errors++; $display("[TB] FAIL rb_sharp_drops: got %0d expected 0", sharpDrops); end
        checks++; if (key_code !== 4'hA) begin errors++; $display("[TB] FAIL rb_code: got %h expected A", key_code); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL rb_pulse_count: got %0d expected 1", pulseCount - p0); end
        applyStimulus(11'h000, 6);
        checks++; if (sharp !== 1'b1) begin errors++; $display("[TB] FAIL rb_release_early: got %b expected 1", sharp); end
        tick();
        checks++; if (sharp !== 1'b0) begin errors++; $display("[TB] FAIL rb_release_sharp: got %b expected 0", sharp); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("[TB] FAIL rb_release_code: got %h expected F", key_code); end
        repeat (4) tick();
    endtask

    initial begin
        raw_key = 11'h000;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #2;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_multi_key();
        test_sharp_with_key();
        test_release_bounce();
        checks++; if (doublePulse !== 0) begin errors++; $display("[TB] FAIL back_to_back_pulse: got %0d expected 0", doublePulse); end
        checks++; if (inconsistent !== 0) begin errors++; $display("[TB] FAIL output_consistency: got %0d expected 0", inconsistent); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
